// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames a byte written to output port 0 as
// start / 7 or 8 data bits / optional parity / stop bits, shifts it out
// LSB first at BAUD_K clocks per bit, and reports completion via TXRDY
// and a single-clock TX_INT pulse.
module uart_tx_engine #(
  parameter int unsigned BAUD_W    = 19,
  parameter int unsigned FRAME_LEN = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LOAD,
  input  logic [7:0]        OUT_PORT,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  input  logic [BAUD_W-1:0] BAUD_K,
  output logic              TX,
  output logic              TXRDY,
  output logic              TX_INT
);

  localparam int unsigned BIT_W = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [BAUD_W-1:0]      baud_cnt, baud_cnt_d;
  logic [BAUD_W-1:0]      baud_k, baud_k_d;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_d;
  logic                   tx_d, txrdy_d, tx_int_d;
  logic [FRAME_LEN-1:0]   frame_c;

  // Build the LSB-first frame: start bit, data, optional parity, mark fill.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic [7:0] d,
    input logic       eight,
    input logic       pen,
    input logic       ohel
  );
    logic [FRAME_LEN-1:0] f;
    logic                 p;
    f      = '1;
    f[0]   = 1'b0;
    f[7:1] = d[6:0];
    p      = (^d[6:0]) ^ ohel;
    if (eight) begin
      f[8] = d[7];
      p    = p ^ d[7];
      if (pen) f[9] = p;
    end else if (pen) begin
      f[8] = p;
    end
    return f;
  endfunction

  assign frame_c = build_frame(OUT_PORT, EIGHT, PEN, OHEL);

  // State and datapath registers; reset forces the line to mark immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift_q  <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      baud_k   <= BAUD_W'(1);
      TX       <= 1'b1;
      TXRDY    <= 1'b1;
      TX_INT   <= 1'b0;
    end else begin
      state    <= state_d;
      shift_q  <= shift_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      baud_k   <= baud_k_d;
      TX       <= tx_d;
      TXRDY    <= txrdy_d;
      TX_INT   <= tx_int_d;
    end
  end

  // Next-state and next-output logic; LOAD is only honoured while idle.
  always_comb begin
    state_d    = state;
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt;
    bit_cnt_d  = bit_cnt;
    baud_k_d   = baud_k;
    tx_d       = TX;
    txrdy_d    = TXRDY;
    tx_int_d   = 1'b0;
    case (state)
      IDLE: begin
        tx_d    = 1'b1;
        txrdy_d = 1'b1;
        if (LOAD) begin
          shift_d    = frame_c;
          tx_d       = frame_c[0];
          txrdy_d    = 1'b0;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          baud_k_d   = (BAUD_K == '0) ? BAUD_W'(1) : BAUD_K;
          state_d    = SEND;
        end
      end
      SEND: begin
        txrdy_d = 1'b0;
        if (baud_cnt == baud_k - BAUD_W'(1)) begin
          baud_cnt_d = '0;
          if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
            state_d   = IDLE;
            txrdy_d   = 1'b1;
            tx_int_d  = 1'b1;
            tx_d      = 1'b1;
            shift_d   = '1;
            bit_cnt_d = '0;
          end else begin
            shift_d   = {1'b1, shift_q[FRAME_LEN-1:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
